// File: rtl/reg_alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_alu_seq_pkg
// Description : Command kinds, FSM encoding and packed command width helper.
// Revision    : 1.0
// ============================================================================
package reg_alu_seq_pkg;

    localparam logic [1:0] KIND_NOP  = 2'b00;
    localparam logic [1:0] KIND_LOAD = 2'b01;
    localparam logic [1:0] KIND_ALU  = 2'b10;
    localparam logic [1:0] KIND_READ = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_CARRY = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Packed command layout, MSB first: kind, op, ra, rb, rd, imm.
    function automatic int cmd_width(input int aw, input int dw);
        return 2 + 2 + 3 * aw + dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_alu_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : seq_cmd_fifo
// Description : Synchronous command FIFO with extra-MSB pointers for full/empty.
// Revision    : 1.0
// ============================================================================
module seq_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0]      r_wr_ptr;
    logic [c_aw:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_push_ok;
    logic               w_pop_ok;

    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[c_aw-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr[c_aw-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    // Same slot index but lapped once: every entry is occupied.
    assign o_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

endmodule
`default_nettype wire

// File: rtl/reg_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : reg_alu_seq
// Description : Command sequencer driving the reg_alu register-file/ALU datapath.
// Revision    : 1.0
// ============================================================================
module reg_alu_seq
    import reg_alu_seq_pkg::*;
#(
    parameter int DW         = 16,
    parameter int AW         = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_kind,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_ra,
    input  logic [AW-1:0] cmd_rb,
    input  logic [AW-1:0] cmd_rd,
    input  logic [DW-1:0] cmd_imm,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          carry_flag,
    output logic          busy,
    output logic [7:0]    exec_count,
    output logic          dp_sel,
    output logic          dp_wr,
    output logic [1:0]    dp_op,
    output logic [AW-1:0] dp_rd_addr_a,
    output logic [AW-1:0] dp_rd_addr_b,
    output logic [AW-1:0] dp_wr_addr,
    output logic [DW-1:0] dp_d_in,
    input  logic [DW-1:0] dp_d_out_a,
    input  logic          dp_cout
);

    localparam int c_cmd_w = cmd_width(AW, DW);

    logic [c_cmd_w-1:0] w_cmd_in;
    logic [c_cmd_w-1:0] w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_push;

    logic [1:0]         w_head_kind;
    logic [1:0]         w_head_op;
    logic [AW-1:0]      w_head_ra;
    logic [AW-1:0]      w_head_rb;
    logic [AW-1:0]      w_head_rd;
    logic [DW-1:0]      w_head_imm;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [1:0]         r_kind;

    logic               w_pop;
    logic               w_exec;
    logic               w_count_inc;
    logic               w_rsp_load;
    logic               w_rsp_clear;
    logic               w_carry_load;

    logic               r_rsp_valid;
    logic [DW-1:0]      r_rsp_data;
    logic               r_carry;
    logic [7:0]         r_exec_count;
    logic               r_dp_sel;
    logic               r_dp_wr;
    logic [1:0]         r_dp_op;
    logic [AW-1:0]      r_dp_ra;
    logic [AW-1:0]      r_dp_rb;
    logic [AW-1:0]      r_dp_rd;
    logic [DW-1:0]      r_dp_imm;

    assign w_push   = cmd_valid && !w_full;
    assign w_cmd_in = {cmd_kind, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_imm};

    seq_cmd_fifo #(
        .WIDTH (c_cmd_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_cmd_in),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_kind = w_head[c_cmd_w-1 -: 2];
    assign w_head_op   = w_head[c_cmd_w-3 -: 2];
    assign w_head_ra   = w_head[DW+3*AW-1 -: AW];
    assign w_head_rb   = w_head[DW+2*AW-1 -: AW];
    assign w_head_rd   = w_head[DW+AW-1 -: AW];
    assign w_head_imm  = w_head[DW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (!w_empty) w_state_nxt = ST_EXEC;
            ST_EXEC: begin
                case (r_kind)
                    KIND_ALU:  w_state_nxt = ST_CARRY;
                    KIND_READ: w_state_nxt = ST_RESP;
                    default:   w_state_nxt = ST_IDLE;
                endcase
            end
            ST_CARRY: w_state_nxt = ST_IDLE;
            ST_RESP:  if (rsp_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pop        = 1'b0;
        w_exec       = 1'b0;
        w_count_inc  = 1'b0;
        w_rsp_load   = 1'b0;
        w_rsp_clear  = 1'b0;
        w_carry_load = 1'b0;
        case (r_state)
            ST_IDLE:  w_pop = !w_empty;
            ST_EXEC: begin
                w_exec      = 1'b1;
                w_count_inc = (r_kind != KIND_READ);
                w_rsp_load  = (r_kind == KIND_READ);
            end
            ST_CARRY: w_carry_load = 1'b1;
            ST_RESP: begin
                w_count_inc = rsp_ready;
                w_rsp_clear = rsp_ready;
            end
            default: ;
        endcase
    end

    // Datapath controls load from the FIFO head on the pop edge so they are
    // valid for the whole EXEC cycle; addresses persist through CARRY.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kind   <= KIND_NOP;
            r_dp_sel <= 1'b0;
            r_dp_wr  <= 1'b0;
            r_dp_op  <= 2'b00;
            r_dp_ra  <= '0;
            r_dp_rb  <= '0;
            r_dp_rd  <= '0;
            r_dp_imm <= '0;
        end else if (w_pop) begin
            r_kind   <= w_head_kind;
            r_dp_sel <= (w_head_kind == KIND_ALU);
            r_dp_wr  <= (w_head_kind == KIND_ALU) || (w_head_kind == KIND_LOAD);
            r_dp_op  <= w_head_op;
            r_dp_ra  <= w_head_ra;
            r_dp_rb  <= w_head_rb;
            r_dp_rd  <= w_head_rd;
            r_dp_imm <= w_head_imm;
        end else if (w_exec) begin
            r_dp_wr  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_carry      <= 1'b0;
            r_exec_count <= 8'd0;
        end else begin
            if (w_rsp_load) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= dp_d_out_a;
            end else if (w_rsp_clear) begin
                r_rsp_valid <= 1'b0;
            end
            if (w_carry_load) r_carry      <= dp_cout;
            if (w_count_inc)  r_exec_count <= r_exec_count + 8'd1;
        end
    end

    assign cmd_ready    = !w_full;
    assign busy         = (r_state != ST_IDLE) || !w_empty;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign carry_flag   = r_carry;
    assign exec_count   = r_exec_count;
    assign dp_sel       = r_dp_sel;
    assign dp_wr        = r_dp_wr;
    assign dp_op        = r_dp_op;
    assign dp_rd_addr_a = r_dp_ra;
    assign dp_rd_addr_b = r_dp_rb;
    assign dp_wr_addr   = r_dp_rd;
    assign dp_d_in      = r_dp_imm;

endmodule
`default_nettype wire

// File: tb/tb_reg_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_alu_seq
// Description : Self-checking bench for reg_alu_seq with a behavioural datapath.
// Revision    : 1.0
// ============================================================================
module tb_reg_alu_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_kind = 2'b00;
    logic [1:0]  cmd_op = 2'b00;
    logic [2:0]  cmd_ra = 3'd0;
    logic [2:0]  cmd_rb = 3'd0;
    logic [2:0]  cmd_rd = 3'd0;
    logic [15:0] cmd_imm = 16'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        carry_flag;
    logic        busy;
    logic [7:0]  exec_count;
    logic        dp_sel;
    logic        dp_wr;
    logic [1:0]  dp_op;
    logic [2:0]  dp_rd_addr_a;
    logic [2:0]  dp_rd_addr_b;
    logic [2:0]  dp_wr_addr;
    logic [15:0] dp_d_in;
    logic [15:0] dp_d_out_a;
    logic        dp_cout_r = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    reg_alu_seq #(.DW(16), .AW(3), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
        .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .carry_flag(carry_flag), .busy(busy), .exec_count(exec_count),
        .dp_sel(dp_sel), .dp_wr(dp_wr), .dp_op(dp_op),
        .dp_rd_addr_a(dp_rd_addr_a), .dp_rd_addr_b(dp_rd_addr_b),
        .dp_wr_addr(dp_wr_addr), .dp_d_in(dp_d_in),
        .dp_d_out_a(dp_d_out_a), .dp_cout(dp_cout_r)
    );

    // ALU of the attached datapath: 00 add, 01 sub (borrow as carry), 10 and, 11 xor.
    function automatic logic [16:0] alu_f(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} - {1'b0, b};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    logic [15:0] dp_regs [8] = '{default: 16'h0000};
    logic [16:0] stub_res;
    assign dp_d_out_a = dp_regs[dp_rd_addr_a];
    assign stub_res   = alu_f(dp_op, dp_regs[dp_rd_addr_a], dp_regs[dp_rd_addr_b]);

    always @(posedge clk) begin
        if (dp_wr) begin
            if (dp_sel) begin
                dp_regs[dp_wr_addr] <= stub_res[15:0];
                dp_cout_r           <= stub_res[16];
            end else begin
                dp_regs[dp_wr_addr] <= dp_d_in;
            end
        end
    end

    // Architectural reference: each accepted command is applied in order.
    logic [15:0] m_regs [8] = '{default: 16'h0000};
    logic        m_carry = 1'b0;
    int          m_count = 0;
    int          m_writes = 0;
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    int          wr_pulses = 0;

    function automatic void model_apply(input logic [1:0] k, input logic [1:0] op,
                                        input logic [2:0] ra, input logic [2:0] rb,
                                        input logic [2:0] rd, input logic [15:0] imm);
        logic [16:0] r;
        case (k)
            2'b01: begin m_regs[rd] = imm; m_writes++; end
            2'b10: begin
                r = alu_f(op, m_regs[ra], m_regs[rb]);
                m_regs[rd] = r[15:0];
                m_carry = r[16];
                m_writes++;
            end
            2'b11: exp_q.push_back(m_regs[ra]);
            default: ;
        endcase
        m_count++;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (dp_wr) wr_pulses++;
            if (rsp_valid && rsp_ready) obs_q.push_back(rsp_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic push_cmd(input logic [1:0] k, input logic [1:0] op, input logic [2:0] ra,
                            input logic [2:0] rb, input logic [2:0] rd, input logic [15:0] imm);
        int t = 0;
        cmd_valid = 1'b1; cmd_kind = k; cmd_op = op;
        cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_imm = imm;
        @(negedge clk);
        while (!cmd_ready && t < 300) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (t >= 300) begin
            total++; bad++;
            $display("FAIL push_timeout cmd_ready stayed 0, required 1");
        end else begin
            model_apply(k, op, ra, rb, rd, imm);
        end
    endtask

    task automatic drain(output bit ok);
        int t = 0;
        @(negedge clk);
        while ((busy || rsp_valid) && t < 3000) begin @(negedge clk); t++; end
        ok = (t < 3000);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0) begin bad++; $display("FAIL rst_rsp got=%b/%h exp=0/0000", rsp_valid, rsp_data); end
        total++; if (exec_count !== 8'd0 || carry_flag !== 1'b0) begin bad++; $display("FAIL rst_cnt_carry got=%0d/%b exp=0/0", exec_count, carry_flag); end
        total++; if ({dp_sel, dp_wr, dp_op, dp_rd_addr_a, dp_rd_addr_b, dp_wr_addr, dp_d_in} !== '0) begin
            bad++; $display("FAIL rst_dp got=%b%b %h %h exp=all zero", dp_sel, dp_wr, dp_op, dp_d_in);
        end
        reset = 1'b1;
        tick(1);
        total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rst_release got=%b/%b exp=1/0", cmd_ready, busy); end
    endtask

    task automatic test_load_read();
        bit ok;
        logic [15:0] got;
        rsp_ready = 1'b1;
        push_cmd(2'b01, 2'b00, 3'd0, 3'd0, 3'd3, 16'h1234);
        push_cmd(2'b11, 2'b00, 3'd3, 3'd0, 3'd0, 16'h0000);
        drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL lr_drain busy stuck got=1 exp=0"); end
        total++; if (obs_q.size() != 1) begin bad++; $display("FAIL lr_rsp_count got=%0d exp=1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            total++; if (got !== 16'h1234) begin bad++; $display("FAIL lr_rsp got=%h exp=1234", got); end
        end
        total++; if (exec_count !== 8'd2) begin bad++; $display("FAIL lr_exec_count got=%0d exp=2", exec_count); end
        total++; if (wr_pulses != 1) begin bad++; $display("FAIL lr_wr_pulses got=%0d exp=1", wr_pulses); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_carry();
        bit ok;
        logic [15:0] got;
        rsp_ready = 1'b1;
        push_cmd(2'b01, 2'b00, 3'd0, 3'd0, 3'd1, 16'hFFFF);
        push_cmd(2'b01, 2'b00, 3'd0, 3'd0, 3'd2, 16'h0001);
        push_cmd(2'b10, 2'b00, 3'd1, 3'd2, 3'd4, 16'h0000);
        push_cmd(2'b11, 2'b00, 3'd4, 3'd0, 3'd0, 16'h0000);
        drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL cy_drain busy stuck got=1 exp=0"); end
        total++; if (obs_q.size() != 1) begin bad++; $display("FAIL cy_rsp_count got=%0d exp=1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            total++; if (got !== 16'h0000) begin bad++; $display("FAIL cy_rsp got=%h exp=0000", got); end
        end
        total++; if (carry_flag !== 1'b1) begin bad++; $display("FAIL cy_carry got=%b exp=1", carry_flag); end
        total++; if (exec_count !== 8'(m_count)) begin bad++; $display("FAIL cy_exec_count got=%0d exp=%0d", exec_count, 8'(m_count)); end
        total++; if (wr_pulses != m_writes) begin bad++; $display("FAIL cy_wr_pulses got=%0d exp=%0d", wr_pulses, m_writes); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        bit ok;
        int t = 0;
        logic [15:0] held;
        logic [15:0] got;
        logic [15:0] exp;
        rsp_ready = 1'b0;
        push_cmd(2'b11, 2'b00, 3'd4, 3'd0, 3'd0, 16'h0000);
        while (!rsp_valid && t < 20) begin tick(1); t++; end
        total++; if (t >= 20) begin bad++; $display("FAIL bp_rsp_valid got=0 exp=1"); end
        push_cmd(2'b01, 2'b00, 3'd0, 3'd0, 3'd5, 16'($urandom));
        push_cmd(2'b10, 2'($urandom_range(0, 3)), 3'd5, 3'd1, 3'd6, 16'h0000);
        push_cmd(2'b11, 2'b00, 3'd6, 3'd0, 3'd0, 16'h0000);
        push_cmd(2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0000);
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", cmd_ready); end
        held = rsp_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== held || dp_wr !== 1'b0) begin
                bad++; $display("FAIL bp_stall cyc=%0d got=%b/%h/%b exp=1/%h/0", i, rsp_valid, rsp_data, dp_wr, held);
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        push_cmd(2'b11, 2'b00, 3'd5, 3'd0, 3'd0, 16'h0000);
        drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_drain busy stuck got=1 exp=0"); end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_rsp_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); exp = exp_q.pop_front();
            total++; if (got !== exp) begin bad++; $display("FAIL bp_rsp got=%h exp=%h", got, exp); end
        end
        total++; if (exec_count !== 8'(m_count) || carry_flag !== m_carry) begin
            bad++; $display("FAIL bp_state got=%0d/%b exp=%0d/%b", exec_count, carry_flag, 8'(m_count), m_carry);
        end
        total++; if (wr_pulses != m_writes) begin bad++; $display("FAIL bp_wr_pulses got=%0d exp=%0d", wr_pulses, m_writes); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_nop_wrap();
        bit ok;
        int w0;
        rsp_ready = 1'b1;
        w0 = wr_pulses;
        for (int i = 0; i < 256; i++) push_cmd(2'b00, 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
        drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL nop_drain busy stuck got=1 exp=0"); end
        total++; if (exec_count !== 8'(m_count)) begin bad++; $display("FAIL nop_wrap got=%0d exp=%0d", exec_count, 8'(m_count)); end
        total++; if (wr_pulses != w0) begin bad++; $display("FAIL nop_writes got=%0d exp=%0d", wr_pulses - w0, 0); end
        total++; if (carry_flag !== m_carry) begin bad++; $display("FAIL nop_carry got=%b exp=%b", carry_flag, m_carry); end
    endtask

    task automatic test_reset_mid_alu();
        bit ok;
        int t = 0;
        logic [15:0] snap [8];
        logic [15:0] got;
        logic [15:0] imm;
        rsp_ready = 1'b1;
        push_cmd(2'b01, 2'b00, 3'd0, 3'd0, 3'd5, 16'hFFF0);
        push_cmd(2'b01, 2'b00, 3'd0, 3'd0, 3'd6, 16'h0031);
        drain(ok);
        snap = m_regs;
        push_cmd(2'b10, 2'b00, 3'd5, 3'd6, 3'd7, 16'h0000);
        @(negedge clk);
        while (!dp_wr && t < 20) begin @(negedge clk); t++; end
        total++; if (t >= 20) begin bad++; $display("FAIL rm_exec_seen dp_wr got=0 exp=1"); end
        #2 reset = 1'b0;
        #1;
        total++; if (dp_wr !== 1'b0) begin bad++; $display("FAIL rm_dp_wr got=%b exp=0", dp_wr); end
        total++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL rm_busy_ready got=%b/%b exp=0/1", busy, cmd_ready); end
        total++; if (carry_flag !== 1'b0 || exec_count !== 8'd0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rm_state got=%b/%0d/%b exp=0/0/0", carry_flag, exec_count, rsp_valid);
        end
        m_regs = snap; m_carry = 1'b0; m_count = 0; m_writes = 0; wr_pulses = 0;
        obs_q.delete(); exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        tick(1);
        imm = 16'($urandom);
        push_cmd(2'b01, 2'b00, 3'd0, 3'd0, 3'd7, imm);
        push_cmd(2'b11, 2'b00, 3'd7, 3'd0, 3'd0, 16'h0000);
        push_cmd(2'b11, 2'b00, 3'd5, 3'd0, 3'd0, 16'h0000);
        drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL rm_drain busy stuck got=1 exp=0"); end
        total++; if (obs_q.size() != 2) begin bad++; $display("FAIL rm_rsp_count got=%0d exp=2", obs_q.size()); end
        if (obs_q.size() == 2) begin
            got = obs_q.pop_front();
            total++; if (got !== imm) begin bad++; $display("FAIL rm_rsp_load got=%h exp=%h", got, imm); end
            got = obs_q.pop_front();
            total++; if (got !== 16'hFFF0) begin bad++; $display("FAIL rm_rsp_r5 got=%h exp=fff0", got); end
        end
        total++; if (exec_count !== 8'd3 || carry_flag !== 1'b0) begin bad++; $display("FAIL rm_after got=%0d/%b exp=3/0", exec_count, carry_flag); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        bit ok;
        bit done = 1'b0;
        logic [15:0] got;
        logic [15:0] exp;
        fork
            begin
                for (int i = 0; i < 60; i++)
                    push_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 3'($urandom),
                             3'($urandom), 3'($urandom), 16'($urandom));
                done = 1'b1;
            end
            begin
                while (!done) begin rsp_ready = 1'($urandom_range(0, 1)); tick(1); end
            end
        join
        rsp_ready = 1'b1;
        drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL rnd_drain busy stuck got=1 exp=0"); end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_rsp_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); exp = exp_q.pop_front();
            total++; if (got !== exp) begin bad++; $display("FAIL rnd_rsp got=%h exp=%h", got, exp); end
        end
        total++; if (exec_count !== 8'(m_count)) begin bad++; $display("FAIL rnd_exec_count got=%0d exp=%0d", exec_count, 8'(m_count)); end
        total++; if (carry_flag !== m_carry) begin bad++; $display("FAIL rnd_carry got=%b exp=%b", carry_flag, m_carry); end
        total++; if (wr_pulses != m_writes) begin bad++; $display("FAIL rnd_wr_pulses got=%0d exp=%0d", wr_pulses, m_writes); end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_load_read();
        test_carry();
        test_backpressure();
        test_nop_wrap();
        test_reset_mid_alu();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
